// File: rtl/sparc_exu_alu_pkg.sv
// sparc_exu_alu_pkg
// Shared types for the EXU integer ALU: the opcode encoding, the per-thread
// condition-code register layout {xcc.nzvc, icc.nzvc}, and a helper that
// flags addresses falling in the unimplemented VA hole.
package sparc_exu_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_XOR   = 3'd3,
        OP_MOVE  = 3'd4,
        OP_RS3   = 3'd5,
        OP_SHIFT = 3'd6
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzvc_t;

    // Packs to {xcc.n,z,v,c, icc.n,z,v,c}, which is the CCR read-port format.
    typedef struct packed {
        nzvc_t xcc;
        nzvc_t icc;
    } ccr_t;

    // Widest datapath the VA helper handles; callers zero-extend into it.
    localparam int VA_MAXW = 128;

    // An address is in the hole when bits [dw-1:vaw-1] are neither all-0
    // nor all-1, i.e. some bit above vaw-1 differs from bit vaw-1.
    function automatic logic va_hole(input logic [VA_MAXW-1:0] a,
                                     input int                 dw,
                                     input int                 vaw);
        logic sgn;
        logic hole;
        sgn  = 1'b0;
        hole = 1'b0;
        for (int i = 0; i < VA_MAXW; i++) begin
            if (i == vaw - 1) sgn = a[i];
        end
        for (int i = 0; i < VA_MAXW; i++) begin
            if (i >= vaw && i < dw && a[i] != sgn) hole = 1'b1;
        end
        return hole;
    endfunction

endpackage

// File: rtl/sparc_exu_alu_flags.sv
// sparc_exu_alu_flags
// Combinational n/z/v/c generation for the 32-bit (icc) and DW-bit (xcc)
// views of an ALU result.
//   res_i    : result being written back
//   a_i, b_i : adder operands (b_i already inverted for subtract)
//   c64_i    : carry/borrow out of bit DW-1
//   c32_i    : carry/borrow out of bit 31
//   is_add_i : v and c are only meaningful for ADD; forced to 0 otherwise
//   xcc_o, icc_o : {n,z,v,c}
module sparc_exu_alu_flags #(
    parameter int DW = 64
) (
    input  logic [DW-1:0] res_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          c64_i,
    input  logic          c32_i,
    input  logic          is_add_i,
    output logic [3:0]    xcc_o,
    output logic [3:0]    icc_o
);

    logic v64;
    logic v32;

    // Signed overflow: operands agree in sign, result disagrees.
    assign v64 = (a_i[DW-1] == b_i[DW-1]) && (res_i[DW-1] != a_i[DW-1]);
    assign v32 = (a_i[31] == b_i[31]) && (res_i[31] != a_i[31]);

    assign xcc_o = {res_i[DW-1], ~|res_i, is_add_i & v64, is_add_i & c64_i};
    assign icc_o = {res_i[31], ~|res_i[31:0], is_add_i & v32, is_add_i & c32_i};

endmodule

// File: rtl/sparc_exu_alu_pipe.sv
// sparc_exu_alu_pipe
// Registered integer ALU with valid/ready handshake and per-thread CCRs.
//   rclk, rst          : clock, synchronous active-high reset
//   in_vld/in_rdy      : operation handshake
//   in_tid, in_op      : thread and opcode (alu_op_e)
//   in_inv, in_usec    : invert rs2 / use icc.c as carry-in on ADD
//   in_setcc           : write the thread's CCR on accept
//   in_rs1..in_shift   : operands
//   out_vld/out_rdy    : result handshake
//   out_tid, out_data  : registered thread and result
//   out_va, out_va_inv : low VA bits of the adder and VA-hole flag
//   ccr_rd_tid/ccr_rd  : combinational CCR read port
module sparc_exu_alu_pipe
    import sparc_exu_alu_pkg::*;
#(
    parameter  int DW   = 64,
    parameter  int VAW  = 48,
    parameter  int NTHR = 4,
    localparam int TW   = (NTHR > 1) ? $clog2(NTHR) : 1
) (
    input  logic            rclk,
    input  logic            rst,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [TW-1:0]   in_tid,
    input  logic [2:0]      in_op,
    input  logic            in_inv,
    input  logic            in_usec,
    input  logic            in_setcc,
    input  logic [DW-1:0]   in_rs1,
    input  logic [DW-1:0]   in_rs2,
    input  logic [DW-1:0]   in_rs3,
    input  logic [DW-1:0]   in_shift,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [TW-1:0]   out_tid,
    output logic [DW-1:0]   out_data,
    output logic [VAW-1:0]  out_va,
    output logic            out_va_inv,
    input  logic [TW-1:0]   ccr_rd_tid,
    output logic [7:0]      ccr_rd
);

    // Storage is sized to the full tid space so any tid value indexes safely.
    localparam int NSLOT = 1 << TW;

    alu_op_e        op;
    logic           acc;
    logic [DW-1:0]  b;
    logic           cin;
    logic [DW:0]    sum_x;
    logic [DW-1:0]  sum;
    logic           c64;
    logic           c32;
    logic [DW-1:0]  res_d;
    logic [3:0]     xcc_w;
    logic [3:0]     icc_w;
    ccr_t           ccr_d;
    ccr_t           cur_ccr;
    logic           out_vld_d;
    logic           va_inv_d;

    logic           out_vld_q;
    logic [TW-1:0]  out_tid_q;
    logic [DW-1:0]  out_data_q;
    logic [VAW-1:0] out_va_q;
    logic           out_va_inv_q;
    ccr_t           ccr_q [NSLOT];

    assign op      = alu_op_e'(in_op);
    assign in_rdy  = ~out_vld_q | out_rdy;
    assign acc     = in_vld & in_rdy;
    assign cur_ccr = ccr_q[in_tid];

    // Adder: subtract is rs1 + ~rs2 + 1; addc/subc fold icc.c into the
    // carry-in with the same inversion so borrow-in behaves like carry-in.
    assign b     = in_inv ? ~in_rs2 : in_rs2;
    assign cin   = in_usec ? (cur_ccr.icc.c ^ in_inv) : in_inv;
    assign sum_x = {1'b0, in_rs1} + {1'b0, b} + {{DW{1'b0}}, cin};
    assign sum   = sum_x[DW-1:0];

    // Carry into bit 32 recovered from the sum; inverting on subtract turns
    // carry into borrow.
    assign c64 = sum_x[DW] ^ in_inv;
    assign c32 = sum[32] ^ in_rs1[32] ^ b[32] ^ in_inv;

    always_comb begin
        res_d = '0;
        case (op)
            OP_ADD:   res_d = sum;
            OP_AND:   res_d = in_rs1 & b;
            OP_OR:    res_d = in_rs1 | b;
            OP_XOR:   res_d = in_rs1 ^ b;
            OP_MOVE:  res_d = b;
            OP_RS3:   res_d = in_rs3;
            OP_SHIFT: res_d = in_shift;
            default:  res_d = '0;
        endcase
    end

    sparc_exu_alu_flags #(.DW(DW)) u_flags (
        .res_i    (res_d),
        .a_i      (in_rs1),
        .b_i      (b),
        .c64_i    (c64),
        .c32_i    (c32),
        .is_add_i (op == OP_ADD),
        .xcc_o    (xcc_w),
        .icc_o    (icc_w)
    );

    assign ccr_d    = ccr_t'({xcc_w, icc_w});
    assign va_inv_d = va_hole({{(VA_MAXW-DW){1'b0}}, sum}, DW, VAW);

    // Accept always reloads; otherwise a taken result empties the register.
    assign out_vld_d = acc ? 1'b1 : (out_rdy ? 1'b0 : out_vld_q);

    always_ff @(posedge rclk) begin
        if (rst) begin
            out_vld_q    <= 1'b0;
            out_tid_q    <= '0;
            out_data_q   <= '0;
            out_va_q     <= '0;
            out_va_inv_q <= 1'b0;
            for (int t = 0; t < NSLOT; t++) ccr_q[t] <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            if (acc) begin
                out_tid_q    <= in_tid;
                out_data_q   <= res_d;
                out_va_q     <= sum[VAW-1:0];
                out_va_inv_q <= va_inv_d;
            end
            if (acc && in_setcc) ccr_q[in_tid] <= ccr_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign out_tid    = out_tid_q;
    assign out_data   = out_data_q;
    assign out_va     = out_va_q;
    assign out_va_inv = out_va_inv_q;
    assign ccr_rd     = ccr_q[ccr_rd_tid];

endmodule

// File: tb/tb_sparc_exu_alu_pipe.sv
module tb_sparc_exu_alu_pipe;
    import sparc_exu_alu_pkg::*;

    logic        rclk;
    logic        rst;

    // Main instance: DW=64, VAW=48, NTHR=4
    logic        in_vld, in_rdy, in_inv, in_usec, in_setcc;
    logic [1:0]  in_tid, out_tid, ccr_rd_tid;
    logic [2:0]  in_op;
    logic [63:0] in_rs1, in_rs2, in_rs3, in_shift, out_data;
    logic        out_vld, out_rdy, out_va_inv;
    logic [47:0] out_va;
    logic [7:0]  ccr_rd;

    // Sweep instance: DW=40, VAW=32, NTHR=1
    logic        b_in_vld, b_in_rdy, b_in_inv, b_in_usec, b_in_setcc;
    logic [0:0]  b_in_tid, b_out_tid, b_ccr_rd_tid;
    logic [2:0]  b_in_op;
    logic [39:0] b_in_rs1, b_in_rs2, b_in_rs3, b_in_shift, b_out_data;
    logic        b_out_vld, b_out_rdy, b_out_va_inv;
    logic [31:0] b_out_va;
    logic [7:0]  b_ccr_rd;

    int checks = 0;
    int errors = 0;

    sparc_exu_alu_pipe dut (
        .rclk(rclk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_tid(in_tid), .in_op(in_op),
        .in_inv(in_inv), .in_usec(in_usec), .in_setcc(in_setcc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_shift(in_shift),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_tid(out_tid),
        .out_data(out_data), .out_va(out_va), .out_va_inv(out_va_inv),
        .ccr_rd_tid(ccr_rd_tid), .ccr_rd(ccr_rd)
    );

    sparc_exu_alu_pipe #(.DW(40), .VAW(32), .NTHR(1)) dut_b (
        .rclk(rclk), .rst(rst),
        .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_tid(b_in_tid), .in_op(b_in_op),
        .in_inv(b_in_inv), .in_usec(b_in_usec), .in_setcc(b_in_setcc),
        .in_rs1(b_in_rs1), .in_rs2(b_in_rs2), .in_rs3(b_in_rs3), .in_shift(b_in_shift),
        .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_tid(b_out_tid),
        .out_data(b_out_data), .out_va(b_out_va), .out_va_inv(b_out_va_inv),
        .ccr_rd_tid(b_ccr_rd_tid), .ccr_rd(b_ccr_rd)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_vld = 0; in_tid = 0; in_op = OP_ADD; in_inv = 0; in_usec = 0; in_setcc = 0;
        in_rs1 = 0; in_rs2 = 0; in_rs3 = 0; in_shift = 0; out_rdy = 1; ccr_rd_tid = 0;
        b_in_vld = 0; b_in_tid = 0; b_in_op = OP_ADD; b_in_inv = 0; b_in_usec = 0;
        b_in_setcc = 0; b_in_rs1 = 0; b_in_rs2 = 0; b_in_rs3 = 0; b_in_shift = 0;
        b_out_rdy = 1; b_ccr_rd_tid = 0;

        // Reset state
        tick; tick;
        chk("rst_out_vld",  64'(out_vld), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_va",   64'(out_va), 64'd0);
        chk("rst_va_inv",   64'(out_va_inv), 64'd0);
        chk("rst_out_tid",  64'(out_tid), 64'd0);
        chk("rst_ccr",      64'(ccr_rd), 64'd0);
        chk("rst_in_rdy",   64'(in_rdy), 64'd1);
        chk("rst_b_vld",    64'(b_out_vld), 64'd0);
        chk("rst_b_ccr",    64'(b_ccr_rd), 64'd0);
        rst = 1'b0;
        tick;
        chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);

        // Subtract with borrow: 5 - 7
        in_vld = 1; in_tid = 0; in_op = OP_ADD; in_inv = 1; in_setcc = 1;
        in_rs1 = 64'd5; in_rs2 = 64'd7; ccr_rd_tid = 0;
        #1;
        chk("sub_ccr_before_edge", 64'(ccr_rd), 64'd0);
        tick;
        chk("sub_vld",  64'(out_vld), 64'd1);
        chk("sub_data", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_ccr",  64'(ccr_rd), 64'h99);
        chk("sub_tid",  64'(out_tid), 64'd0);

        // addc chain on thread 2
        in_tid = 2; in_inv = 0; in_rs1 = 64'hFFFF_FFFF; in_rs2 = 64'd1; ccr_rd_tid = 2;
        tick;
        chk("addc1_data", out_data, 64'h1_0000_0000);
        chk("addc1_ccr",  64'(ccr_rd), 64'h05);
        chk("addc1_va",   64'(out_va), 64'h1_0000_0000);
        in_usec = 1; in_setcc = 0; in_rs1 = 64'd0; in_rs2 = 64'd0;
        tick;
        chk("addc2_data", out_data, 64'd1);
        chk("addc2_tid",  64'(out_tid), 64'd2);
        in_vld = 0; in_usec = 0;
        ccr_rd_tid = 0; #1; chk("ccr_t0", 64'(ccr_rd), 64'h99);
        ccr_rd_tid = 1; #1; chk("ccr_t1", 64'(ccr_rd), 64'h00);
        ccr_rd_tid = 3; #1; chk("ccr_t3", 64'(ccr_rd), 64'h00);
        ccr_rd_tid = 2; #1; chk("ccr_t2", 64'(ccr_rd), 64'h05);
        tick;
        chk("drain_vld", 64'(out_vld), 64'd0);

        // VA hole check, back-to-back
        in_vld = 1; in_tid = 0; in_op = OP_ADD; in_rs1 = 64'h0000_7FFF_FFFF_FFFF; in_rs2 = 64'd0;
        tick;
        chk("va1_inv", 64'(out_va_inv), 64'd0);
        chk("va1_va",  64'(out_va), 64'h7FFF_FFFF_FFFF);
        in_rs2 = 64'd1;
        tick;
        chk("va2_data", out_data, 64'h0000_8000_0000_0000);
        chk("va2_inv",  64'(out_va_inv), 64'd1);
        in_rs1 = 64'hFFFF_8000_0000_0000; in_rs2 = 64'd0;
        tick;
        chk("va3_inv", 64'(out_va_inv), 64'd0);

        // Logic and pass ops
        in_op = OP_XOR; in_inv = 1; in_rs1 = 64'h1234; in_rs2 = 64'h1234;
        in_setcc = 1; in_tid = 1; ccr_rd_tid = 1;
        tick;
        chk("xnor_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("xnor_ccr",  64'(ccr_rd), 64'h88);
        in_op = OP_MOVE; in_inv = 0; in_rs2 = 64'd0;
        tick;
        chk("mov0_data", out_data, 64'd0);
        chk("mov0_ccr",  64'(ccr_rd), 64'h44);
        in_op = OP_AND; in_setcc = 0; in_rs1 = 64'hF0F0; in_rs2 = 64'hFF00;
        tick;
        chk("and_data", out_data, 64'hF000);
        chk("and_ccr_kept", 64'(ccr_rd), 64'h44);
        in_op = OP_OR; in_inv = 1; in_rs1 = 64'h0F; in_rs2 = 64'hFFFF_FFFF_FFFF_FF00;
        tick;
        chk("orn_data", out_data, 64'hFF);
        in_op = OP_RS3; in_inv = 0; in_rs3 = 64'h8000_0000; in_setcc = 1;
        in_tid = 3; ccr_rd_tid = 3;
        tick;
        chk("rs3_data", out_data, 64'h8000_0000);
        chk("rs3_ccr",  64'(ccr_rd), 64'h08);
        in_op = OP_SHIFT; in_shift = 64'hDEAD; in_setcc = 0;
        tick;
        chk("shift_data", out_data, 64'hDEAD);

        // Backpressure
        out_rdy = 0; in_op = OP_ADD; in_rs1 = 64'd100; in_rs2 = 64'd0; in_tid = 0;
        #1;
        chk("bp_in_rdy0", 64'(in_rdy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp_hold_data", out_data, 64'hDEAD);
            chk("bp_hold_vld",  64'(out_vld), 64'd1);
            chk("bp_hold_rdy",  64'(in_rdy), 64'd0);
        end
        out_rdy = 1;
        #1;
        chk("bp_in_rdy1", 64'(in_rdy), 64'd1);
        tick;
        chk("bp_next_data", out_data, 64'd100);
        chk("bp_next_vld",  64'(out_vld), 64'd1);
        in_vld = 0;
        tick;
        chk("bp_no_dup", 64'(out_vld), 64'd0);

        // Reset mid-operation
        out_rdy = 0; in_vld = 1; in_op = OP_ADD; in_setcc = 1; in_tid = 0; ccr_rd_tid = 0;
        in_rs1 = 64'h8000_0000_0000_0000; in_rs2 = 64'd0;
        tick;
        chk("mid_held_vld", 64'(out_vld), 64'd1);
        chk("mid_held_ccr", 64'(ccr_rd), 64'h84);
        out_rdy = 1; in_rs1 = 64'd5; rst = 1;
        tick;
        chk("mid_rst_vld",  64'(out_vld), 64'd0);
        chk("mid_rst_ccr",  64'(ccr_rd), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        rst = 0; in_vld = 0; in_setcc = 0;
        tick;

        // Parameter sweep instance
        b_in_vld = 1; b_in_op = OP_ADD; b_in_setcc = 1;
        b_in_rs1 = 40'h7F_FFFF_FFFF; b_in_rs2 = 40'd1;
        tick;
        chk("b_ovf_data", 64'(b_out_data), 64'h80_0000_0000);
        chk("b_ovf_ccr",  64'(b_ccr_rd), 64'hA5);
        chk("b_ovf_vainv", 64'(b_out_va_inv), 64'd1);
        b_in_rs1 = 40'hFF_FFFF_FFFF;
        tick;
        chk("b_wrap_data", 64'(b_out_data), 64'd0);
        chk("b_wrap_ccr",  64'(b_ccr_rd), 64'h55);
        chk("b_wrap_vainv", 64'(b_out_va_inv), 64'd0);
        b_in_vld = 0; rst = 1;
        tick;
        chk("b_rst_vld", 64'(b_out_vld), 64'd0);
        chk("b_rst_ccr", 64'(b_ccr_rd), 64'd0);
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sparc_exu_alu_pipe.md
# sparc_exu_alu_pipe

Parametrised, registered integer ALU for the next-generation EXU. It performs add/sub (with optional carry-in from a per-thread condition-code register), and/or/xor/move with optional rs2 inversion, rs3 pass and shifter pass. Results are held in one output register behind a valid/ready handshake, and a VA range check is computed on the adder result. It sits between the bypass network and the writeback/LSU stage, and owns the integer condition codes (icc/xcc) for `NTHR` threads.

## Interface
- `DW`, default 64: datapath width; must be ≥ 33.
- `VAW`, default 48: implemented VA bits; `DW` > `VAW`.
- `NTHR`, default 4: thread count; the thread-id width is `TW` = clog2(`NTHR`), minimum 1.
- `rclk` input 1: clock.
- `rst` input 1: reset. **One clock; reset is synchronous and active-high.**
- `in_vld` input 1: operation offered.
- `in_rdy` output 1: operation accepted when `in_vld` & `in_rdy`.
- `in_tid` input TW: thread of the operation.
- `in_op` input 3: opcode (package enum) — ADD, AND, OR, XOR, MOVE, RS3, SHIFT.
- `in_inv` input 1: invert rs2 (ADD → subtract; logic → andn/orn/xnor).
- `in_usec` input 1: ADD uses the thread's `icc.c` as carry-in (addc/subc).
- `in_setcc` input 1: update the thread's CCR.
- `in_rs1`, `in_rs2`, `in_rs3`, `in_shift` input DW each: operands.
- `out_vld` output 1: result valid.
- `out_rdy` input 1: consumer takes the result.
- `out_tid` output TW: thread of the result.
- `out_data` output DW: result.
- `out_va` output VAW: `adder[VAW-1:0]`.
- `out_va_inv` output 1: `adder[DW-1:VAW-1]` is not all-0 and not all-1.
- `ccr_rd_tid` input TW: CCR read-port thread select.
- `ccr_rd` output 8: `{xcc.n,z,v,c, icc.n,z,v,c}` for `ccr_rd_tid`; combinational read of the register.

## Operation
- **ADD path**
  - `b` = `in_inv` ? ~`in_rs2` : `in_rs2`.
  - `cin` = `in_usec` ? (`icc.c` ^ `in_inv`) : `in_inv`.
  - `sum` = `rs1` + `b` + `cin`, DW bits.
  - `c64` = carry out of bit DW-1 and `c32` = carry out of bit 31, both XOR `in_inv`. Borrow semantics on subtract.
- **Logic path**: AND/OR/XOR use `b`; MOVE outputs `b`.
- **Pass paths**: RS3 outputs `in_rs3`; SHIFT outputs `in_shift`.
- **Flags (computed at accept)**
  - `xcc`: n = `res[DW-1]`; z = (`res` == 0).
  - `icc`: n = `res[31]`; z = (`res[31:0]` == 0).
  - v, c: signed overflow and carry at the same bit positions for ADD; 0 for every other opcode.
- **CCR update**: when an accepted op has `in_setcc` = 1, `CCR[in_tid]` is written on the same edge that loads the output register. `in_setcc` on RS3 or SHIFT is legal and writes n/z with v = c = 0.
- **CCR read by the next op**: an op accepted on the following cycle reads the updated CCR. No forwarding hazard exists.
- **Backpressure**: `in_rdy` = ~`out_vld` | `out_rdy`. Load the output register on accept. Clear `out_vld` when `out_rdy` is high and there is no accept.
- **Holding**: `out_*` are stable while `out_vld` & ~`out_rdy`.

## Timing
- Latency is one cycle: accept at edge N gives `out_vld` after edge N; throughput is 1 per cycle with `out_rdy` held at 1.
- **Reset**
  - `out_vld` = 0; `out_tid`, `out_data`, `out_va`, `out_va_inv` = 0.
  - All CCRs = 0, so `ccr_rd` = 0.
  - `in_rdy` = 1 in the first cycle after reset.
- **Reset mid-operation**: a held result is discarded and no CCR write occurs on the reset edge, even if `in_vld` is high.
- **Simultaneous output drain and accept**: the new result replaces the old one with no bubble.
- **`ccr_rd_tid` equal to the thread being written**: `ccr_rd` shows the old value until the edge.
- **Wrap**: the adder result is modulo 2^DW. No trap is raised here; overflow is reported only via v.

## Structure
- Package `sparc_exu_alu_pkg`:
  - opcode enum `alu_op_e`;
  - CCR struct `ccr_t` with the `icc`/`xcc` nibble layout;
  - a function for VA hole detection parameterised by `DW`/`VAW`.
- Natural sub-module `sparc_exu_alu_flags`: combinational n/z/v/c generation for the 32-bit and DW-bit views.
- The adder, logic, mux, handshake and CCR array stay in the top.

## Test plan
- **Subtract with borrow**: DW=64, `ADD`, `inv`=1, `setcc`=1, rs1=5, rs2=7 → `out_data`=0xFFFF_FFFF_FFFF_FFFE; `ccr_rd`=0x99 (n=1, c=1 in both).
- **addc chain**: thread 2 adds 0xFFFF_FFFF + 1 with `setcc` → `icc.c`=1. Next cycle `ADD` with `usec`, rs1=0, rs2=0 → `out_data`=1, CCR of other threads unchanged.
- **Backpressure**: hold `out_rdy`=0 for 3 cycles with `in_vld`=1 → `in_rdy`=0 and `out_data` constant. Raising `out_rdy` → next result the following cycle, no drop or duplicate.
- **VA check**: ADD giving 0x0000_7FFF_FFFF_FFFF → `out_va_inv`=0. ADD giving 0x0000_8000_0000_0000 → `out_va_inv`=1. ADD giving 0xFFFF_8000_0000_0000 → `out_va_inv`=0.
- **Logic ops**: XOR with `inv`, rs1=rs2=0x1234 → all-ones, n=1, z=0, v=c=0. MOVE of 0 with `setcc` → z=1 in both icc and xcc.
- **Reset mid-operation**: assert `rst` with a held result and an accepted `setcc` op pending → `out_vld`=0 and `ccr_rd`=0 the next cycle. Re-run with DW=40, VAW=32, NTHR=1 for the parameter sweep.
